// File: rtl/hazard_unit_mc_pkg.sv
// Shared encodings for the RV32 hazard unit and the ID/EXE stages: instruction
// types, operand-forward selects and the multi-cycle unit state.
package hazard_unit_mc_pkg;

  typedef enum logic [2:0] {
    OPT_NONE  = 3'd0,
    OPT_ALU   = 3'd1,
    OPT_LOAD  = 3'd2,
    OPT_STORE = 3'd3,
    OPT_MC    = 3'd4
  } opt_e;

  typedef enum logic [1:0] {
    FWD_RF       = 2'd0,
    FWD_EXE_ALU  = 2'd1,
    FWD_MEM_ALU  = 2'd2,
    FWD_MEM_LOAD = 2'd3
  } fwd_e;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  // Types whose EXE-stage result is not yet available to an ID-stage compare.
  function automatic logic is_alu_or_load(opt_e t);
    return (t == OPT_ALU) || (t == OPT_LOAD);
  endfunction

  // The youngest producer wins: EXE ALU, then MEM ALU, then MEM load data.
  function automatic fwd_e fwd_sel(logic m_exe, logic m_mem, opt_e opt_exe, opt_e opt_mem);
    if (m_exe && opt_exe == OPT_ALU)  return FWD_EXE_ALU;
    if (m_mem && opt_mem == OPT_ALU)  return FWD_MEM_ALU;
    if (m_mem && opt_mem == OPT_LOAD) return FWD_MEM_LOAD;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// ID-stage operand/type information in, pipeline control and forward selects out.
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5
);
  logic              valid_ID;
  logic              branch_ID;
  logic              taken_ID;
  logic              rs1use_ID;
  logic              rs2use_ID;
  logic [REG_AW-1:0] rs1_ID;
  logic [REG_AW-1:0] rs2_ID;
  logic [REG_AW-1:0] rd_ID;
  logic [2:0]        optype_ID;
  logic [REG_AW-1:0] rd_EXE;
  logic [REG_AW-1:0] rd_MEM;
  logic [REG_AW-1:0] rs2_EXE;

  logic              PC_EN_IF;
  logic              reg_FD_stall;
  logic              reg_FD_flush;
  logic              reg_DE_flush;
  logic [1:0]        forward_ctrl_A;
  logic [1:0]        forward_ctrl_B;
  logic              forward_ctrl_ls;
  logic              fwd_br_A;
  logic              fwd_br_B;
  logic              mc_busy;
  logic [REG_AW-1:0] mc_rd;
  logic              mc_wb_EN;

  modport master (
    output valid_ID, branch_ID, taken_ID, rs1use_ID, rs2use_ID,
           rs1_ID, rs2_ID, rd_ID, optype_ID, rd_EXE, rd_MEM, rs2_EXE,
    input  PC_EN_IF, reg_FD_stall, reg_FD_flush, reg_DE_flush,
           forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls,
           fwd_br_A, fwd_br_B, mc_busy, mc_rd, mc_wb_EN
  );

  modport slave (
    input  valid_ID, branch_ID, taken_ID, rs1use_ID, rs2use_ID,
           rs1_ID, rs2_ID, rd_ID, optype_ID, rd_EXE, rd_MEM, rs2_EXE,
    output PC_EN_IF, reg_FD_stall, reg_FD_flush, reg_DE_flush,
           forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls,
           fwd_br_A, fwd_br_B, mc_busy, mc_rd, mc_wb_EN
  );
endinterface

// File: rtl/hazard_unit_mc_mc_scoreboard.sv
// Busy scoreboard for the non-pipelined mul/div unit: tracks the one in-flight
// destination, counts down to its write-back pulse and reports ID conflicts.
module mc_scoreboard
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_mc_i,
  input  logic              mc_id_i,
  input  logic              rs1use_i,
  input  logic              rs2use_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              busy_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              wb_en_o,
  output logic              raw_o,
  output logic              waw_o,
  output logic              struct_o
);
  localparam int CW = $clog2(MC_LAT + 1);

  mc_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // the state only clears on an edge where rst_n is low.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // NOTE: every next-state signal is given its hold value first so no path
  // through the case leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    case (state_q)
      MC_IDLE: if (issue_mc_i) begin
        state_d = MC_BUSY;
        cnt_d   = CW'(MC_LAT);
        rd_d    = rd_i;
      end
      MC_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = MC_IDLE;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  assign busy_o   = (state_q == MC_BUSY);
  assign rd_o     = rd_q;
  assign wb_en_o  = busy_o && (cnt_q == CW'(1));
  // The write-back cycle still counts as busy, so dependents release one cycle later.
  assign raw_o    = busy_o && (rd_q != '0) &&
                    ((rs1use_i && rs1_i == rd_q) || (rs2use_i && rs2_i == rd_q));
  assign waw_o    = busy_o && (rd_i != '0) && (rd_i == rd_q);
  assign struct_o = busy_o && mc_id_i;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding control beside the ID stage: load-use, ID-branch and
// mul/div stalls, EXE/branch/store-data forward selects and MC write-back.
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int MC_LAT       = 8,
  parameter int BRANCH_IN_ID = 1
) (
  input logic             clk,
  input logic             rst_n,
  hazard_unit_mc_if.slave hz
);
  opt_e opt_id, opt_exe_q, opt_exe_d, opt_mem_q;
  logic m1_exe, m2_exe, m1_mem, m2_mem;
  logic load_stall, br_stall, mc_stall, stall, issue, br_en;
  logic mc_raw, mc_waw, mc_struct;

  function automatic logic rs_match(logic use_b, logic [REG_AW-1:0] rs, logic [REG_AW-1:0] rd);
    return use_b && (rs == rd) && (rd != '0);
  endfunction

  assign opt_id = opt_e'(hz.optype_ID);
  assign m1_exe = rs_match(hz.rs1use_ID, hz.rs1_ID, hz.rd_EXE);
  assign m2_exe = rs_match(hz.rs2use_ID, hz.rs2_ID, hz.rd_EXE);
  assign m1_mem = rs_match(hz.rs1use_ID, hz.rs1_ID, hz.rd_MEM);
  assign m2_mem = rs_match(hz.rs2use_ID, hz.rs2_ID, hz.rd_MEM);

  // A store only needs rs2 in MEM, where the load data is bypassed instead.
  assign load_stall = (opt_exe_q == OPT_LOAD) &&
                      (m1_exe || (m2_exe && opt_id != OPT_STORE));
  assign br_en      = (BRANCH_IN_ID != 0) && hz.branch_ID;
  assign br_stall   = br_en &&
                      (((m1_exe || m2_exe) && is_alu_or_load(opt_exe_q)) ||
                       ((m1_mem || m2_mem) && opt_mem_q == OPT_LOAD));
  assign mc_stall   = mc_raw || mc_waw || mc_struct;
  assign stall      = hz.valid_ID && (load_stall || br_stall || mc_stall);
  assign issue      = hz.valid_ID && !stall;

  assign hz.PC_EN_IF     = !stall;
  assign hz.reg_FD_stall = stall;
  assign hz.reg_DE_flush = stall;
  assign hz.reg_FD_flush = hz.taken_ID && !stall;

  assign hz.forward_ctrl_A  = fwd_sel(m1_exe, m1_mem, opt_exe_q, opt_mem_q);
  assign hz.forward_ctrl_B  = fwd_sel(m2_exe, m2_mem, opt_exe_q, opt_mem_q);
  assign hz.forward_ctrl_ls = (hz.rs2_EXE == hz.rd_MEM) && (hz.rd_MEM != '0) &&
                              (opt_exe_q == OPT_STORE) && (opt_mem_q == OPT_LOAD);
  assign hz.fwd_br_A = (BRANCH_IN_ID != 0) && m1_mem && (opt_mem_q == OPT_ALU);
  assign hz.fwd_br_B = (BRANCH_IN_ID != 0) && m2_mem && (opt_mem_q == OPT_ALU);

  // MC results never use the forward network, so they travel down the pipe as NONE.
  always_comb begin
    opt_exe_d = OPT_NONE;
    if (issue && opt_id != OPT_MC) opt_exe_d = opt_id;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opt_exe_q <= OPT_NONE;
      opt_mem_q <= OPT_NONE;
    end else begin
      opt_exe_q <= opt_exe_d;
      opt_mem_q <= opt_exe_q;
    end
  end

  mc_scoreboard #(
    .REG_AW (REG_AW),
    .MC_LAT (MC_LAT)
  ) u_mc_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_mc_i (issue && opt_id == OPT_MC),
    .mc_id_i    (opt_id == OPT_MC),
    .rs1use_i   (hz.rs1use_ID),
    .rs2use_i   (hz.rs2use_ID),
    .rs1_i      (hz.rs1_ID),
    .rs2_i      (hz.rs2_ID),
    .rd_i       (hz.rd_ID),
    .busy_o     (hz.mc_busy),
    .rd_o       (hz.mc_rd),
    .wb_en_o    (hz.mc_wb_EN),
    .raw_o      (mc_raw),
    .waw_o      (mc_waw),
    .struct_o   (mc_struct)
  );

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: load-use, ID branch, mul/div scoreboard,
// store-data bypass, forward priority and reset of an in-flight MC op.
module tb_hazard_unit_mc;
  import hazard_unit_mc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  hazard_unit_mc_if #(.REG_AW(5)) hif ();

  hazard_unit_mc #(
    .REG_AW       (5),
    .MC_LAT       (8),
    .BRANCH_IN_ID (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic id(input logic v, input logic br, input logic tk,
                    input logic u1, input logic u2,
                    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                    input logic [2:0] op);
    hif.valid_ID  = v;
    hif.branch_ID = br;
    hif.taken_ID  = tk;
    hif.rs1use_ID = u1;
    hif.rs2use_ID = u2;
    hif.rs1_ID    = r1;
    hif.rs2_ID    = r2;
    hif.rd_ID     = rd;
    hif.optype_ID = op;
  endtask

  task automatic pipe(input logic [4:0] re, input logic [4:0] rm, input logic [4:0] s2e);
    hif.rd_EXE  = re;
    hif.rd_MEM  = rm;
    hif.rs2_EXE = s2e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0, OPT_NONE);
    pipe(0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    check("rst_pc_en", hif.PC_EN_IF, 1);
    check("rst_fd_stall", hif.reg_FD_stall, 0);
    check("rst_fwd_a", hif.forward_ctrl_A, 0);
    check("rst_fwd_b", hif.forward_ctrl_B, 0);
    check("rst_fwd_ls", hif.forward_ctrl_ls, 0);
    check("rst_mc_busy", hif.mc_busy, 0);
    check("rst_mc_wb", hif.mc_wb_EN, 0);

    // 1: lw x5 then add x6,x5,x1
    rst_n = 1'b1;
    id(1, 0, 0, 1, 0, 2, 0, 5, OPT_LOAD);
    settle();
    check("lw5_issue", hif.PC_EN_IF, 1);
    tick(); pipe(5, 0, 0); id(1, 0, 0, 1, 1, 5, 1, 6, OPT_ALU); settle();
    check("lu_pc_en", hif.PC_EN_IF, 0);
    check("lu_de_flush", hif.reg_DE_flush, 1);
    check("lu_fd_stall", hif.reg_FD_stall, 1);
    tick(); pipe(0, 5, 0); settle();
    check("lu_release", hif.PC_EN_IF, 1);
    check("lu_fwd_a", hif.forward_ctrl_A, 3);
    check("lu_fwd_b", hif.forward_ctrl_B, 0);

    // 2: add x7 then taken beq x7,x0
    tick(); pipe(6, 0, 0); id(1, 0, 0, 1, 1, 1, 2, 7, OPT_ALU); settle();
    check("add7_issue", hif.PC_EN_IF, 1);
    tick(); pipe(7, 6, 0); id(1, 1, 1, 1, 1, 7, 0, 0, OPT_NONE); settle();
    check("br_stall_pc", hif.PC_EN_IF, 0);
    check("br_stall_noflush", hif.reg_FD_flush, 0);
    tick(); pipe(0, 7, 0); settle();
    check("br_release", hif.PC_EN_IF, 1);
    check("br_fwd_a", hif.fwd_br_A, 1);
    check("br_fwd_b", hif.fwd_br_B, 0);
    check("br_fd_flush", hif.reg_FD_flush, 1);

    // 3: mul x9 then dependent add x3,x9,x1
    tick(); pipe(0, 0, 0); id(1, 0, 0, 1, 1, 1, 2, 9, OPT_MC); settle();
    check("mul_idle", hif.mc_busy, 0);
    check("mul_issue", hif.PC_EN_IF, 1);
    tick(); id(1, 0, 0, 1, 1, 9, 1, 3, OPT_ALU); settle();
    check("mul_busy", hif.mc_busy, 1);
    check("mul_rd", hif.mc_rd, 9);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("raw_pc_c%0d", c), hif.PC_EN_IF, 0);
      check($sformatf("raw_wb_c%0d", c), hif.mc_wb_EN, (c == 8) ? 1 : 0);
      if (c < 8) begin tick(); settle(); end
    end
    tick(); settle();
    check("raw_release", hif.PC_EN_IF, 1);
    check("raw_busy_clr", hif.mc_busy, 0);
    check("raw_wb_clr", hif.mc_wb_EN, 0);

    // 4: WAW, structural and independent while busy
    tick(); pipe(3, 0, 0); id(1, 0, 0, 1, 1, 5, 6, 9, OPT_MC); settle();
    check("mul2_issue", hif.PC_EN_IF, 1);
    tick(); pipe(9, 3, 0); id(1, 0, 0, 1, 1, 1, 2, 9, OPT_ALU); settle();
    check("waw_stall", hif.PC_EN_IF, 0);
    tick(); pipe(0, 9, 0); id(1, 0, 0, 1, 1, 1, 2, 10, OPT_MC); settle();
    check("struct_stall", hif.PC_EN_IF, 0);
    tick(); pipe(0, 0, 0); id(1, 0, 0, 1, 1, 1, 2, 4, OPT_ALU); settle();
    check("indep_issue", hif.PC_EN_IF, 1);
    check("indep_no_bubble", hif.reg_DE_flush, 0);

    // 6: reset while cnt==3 with a RAW waiter in ID
    tick(); pipe(4, 0, 0); id(1, 0, 0, 1, 1, 9, 1, 11, OPT_ALU); settle();
    check("raw2_stall_c4", hif.PC_EN_IF, 0);
    tick(); pipe(0, 4, 0); settle();
    check("raw2_stall_c5", hif.PC_EN_IF, 0);
    tick(); pipe(0, 0, 0); settle();
    check("pre_rst_busy", hif.mc_busy, 1);
    check("pre_rst_wb", hif.mc_wb_EN, 0);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; settle();
    check("post_rst_busy", hif.mc_busy, 0);
    check("post_rst_wb", hif.mc_wb_EN, 0);
    check("post_rst_issue", hif.PC_EN_IF, 1);
    id(0, 0, 0, 0, 0, 0, 0, 0, OPT_NONE);
    for (int c = 0; c < 8; c++) begin
      tick(); settle();
      check($sformatf("no_wb_c%0d", c), hif.mc_wb_EN, 0);
    end

    // 5: lw x5 / sw x5 bypass, then the x0 variant
    tick(); pipe(0, 0, 0); id(1, 0, 0, 1, 0, 2, 0, 5, OPT_LOAD); settle();
    check("lw5b_issue", hif.PC_EN_IF, 1);
    tick(); pipe(5, 0, 0); id(1, 0, 0, 1, 1, 8, 5, 0, OPT_STORE); settle();
    check("sw_rs2_no_stall", hif.PC_EN_IF, 1);
    tick(); pipe(0, 5, 5); id(1, 0, 0, 1, 0, 0, 0, 0, OPT_LOAD); settle();
    check("ls_fwd", hif.forward_ctrl_ls, 1);
    tick(); pipe(0, 0, 0); id(1, 0, 0, 1, 1, 0, 0, 0, OPT_STORE); settle();
    check("sw0_issue", hif.PC_EN_IF, 1);
    tick(); pipe(0, 0, 0); id(1, 0, 0, 1, 1, 0, 1, 12, OPT_ALU); settle();
    check("ls_x0", hif.forward_ctrl_ls, 0);
    check("fwd_a_x0", hif.forward_ctrl_A, 0);

    // EXE-over-MEM forward priority and the use bit
    tick(); pipe(12, 0, 0); id(1, 0, 0, 1, 1, 1, 2, 13, OPT_ALU); settle();
    tick(); pipe(13, 12, 0); id(1, 0, 0, 1, 1, 1, 2, 14, OPT_ALU); settle();
    tick(); pipe(14, 13, 0); id(1, 0, 0, 1, 1, 14, 13, 15, OPT_ALU); settle();
    check("prio_a_exe", hif.forward_ctrl_A, 1);
    check("prio_b_mem", hif.forward_ctrl_B, 2);
    check("prio_pc_en", hif.PC_EN_IF, 1);
    pipe(14, 14, 0); id(1, 0, 0, 1, 1, 14, 14, 15, OPT_ALU); settle();
    check("prio_both_a", hif.forward_ctrl_A, 1);
    check("prio_both_b", hif.forward_ctrl_B, 1);
    id(1, 0, 0, 0, 1, 14, 14, 15, OPT_ALU); settle();
    check("nouse_a", hif.forward_ctrl_A, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
